// File: rtl/drop_controller.sv
// drop_controller: gravity/lock sequencer for the active piece.
// Ports: Clock, Resetn (async low), Start, DropTick, SoftDrop, Pause,
//   canMove (registered checker result) -> checkEnable, YPOS[4:0],
//   lockPiece, pieceActive, gameOver (sticky).
module drop_controller #(
    parameter int SPAWN_Y    = 0,
    parameter int FLOOR_Y    = 16,
    parameter int LOCK_TICKS = 2,
    parameter int SOFT_DIV   = 4
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Start,
    input  logic       DropTick,
    input  logic       SoftDrop,
    input  logic       Pause,
    input  logic       canMove,
    output logic       checkEnable,
    output logic [4:0] YPOS,
    output logic       lockPiece,
    output logic       pieceActive,
    output logic       gameOver
);

    typedef enum logic [2:0] {
        IDLE,
        FALL,
        CHECK,
        EVAL,
        MOVE,
        LOCK
    } state_t;

    localparam logic [4:0] SPAWN = 5'(SPAWN_Y);
    localparam logic [4:0] FLOOR = 5'(FLOOR_Y);
    localparam logic [2:0] LOCK_T = 3'(LOCK_TICKS);
    localparam logic [7:0] SOFT_LAST = 8'(SOFT_DIV - 1);

    state_t     state;
    logic [2:0] lock_cnt;
    logic [7:0] soft_cnt;
    logic       forced;

    logic       tick;
    logic [2:0] lock_inc;

    // Soft drop replaces the level timer with a local divider.
    assign tick = SoftDrop ? (soft_cnt == SOFT_LAST) : DropTick;
    // Saturating increment so a long run of blocks never wraps.
    assign lock_inc = (lock_cnt == 3'd7) ? 3'd7 : lock_cnt + 3'd1;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state       <= IDLE;
            YPOS        <= SPAWN;
            checkEnable <= 1'b0;
            lockPiece   <= 1'b0;
            pieceActive <= 1'b0;
            gameOver    <= 1'b0;
            lock_cnt    <= 3'd0;
            soft_cnt    <= 8'd0;
            forced      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    soft_cnt <= 8'd0;
                    if (Start && !gameOver) begin
                        state       <= FALL;
                        YPOS        <= SPAWN;
                        lock_cnt    <= 3'd0;
                        pieceActive <= 1'b1;
                    end
                end
                FALL: begin
                    if (!SoftDrop) begin
                        soft_cnt <= 8'd0;
                    end else if (!Pause) begin
                        soft_cnt <= (soft_cnt == SOFT_LAST) ? 8'd0
                                                           : soft_cnt + 8'd1;
                    end
                    if (tick && !Pause) begin
                        soft_cnt <= 8'd0;
                        if (YPOS == FLOOR) begin
                            // Floor is a known block: skip the checker.
                            forced <= 1'b1;
                            state  <= EVAL;
                        end else begin
                            forced      <= 1'b0;
                            checkEnable <= 1'b1;
                            state       <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    checkEnable <= 1'b0;
                    state       <= EVAL;
                end
                EVAL: begin
                    forced <= 1'b0;
                    if (!forced && canMove) begin
                        // Row advances here so it is visible in MOVE.
                        lock_cnt <= 3'd0;
                        if (YPOS < FLOOR) begin
                            YPOS <= YPOS + 5'd1;
                        end
                        state <= MOVE;
                    end else begin
                        lock_cnt <= lock_inc;
                        if (lock_inc == LOCK_T) begin
                            lockPiece <= 1'b1;
                            state     <= LOCK;
                        end else begin
                            state <= FALL;
                        end
                    end
                end
                MOVE: begin
                    state <= FALL;
                end
                LOCK: begin
                    lockPiece   <= 1'b0;
                    pieceActive <= 1'b0;
                    if (YPOS == SPAWN) begin
                        gameOver <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drop_controller.sv
// tb_drop_controller: directed bench for drop_controller.
// Ports: none; drives the DUT and models a registered checker.
module tb_drop_controller;

    logic       Clock;
    logic       Resetn;
    logic       Start;
    logic       DropTick;
    logic       SoftDrop;
    logic       Pause;
    logic       canMove;
    logic       checkEnable;
    logic [4:0] YPOS;
    logic       lockPiece;
    logic       pieceActive;
    logic       gameOver;

    logic       resp;
    int         total;
    int         bad;
    int         ce_n;
    int         lk_n;
    logic [4:0] lk_y;

    drop_controller dut (
        .Clock(Clock),
        .Resetn(Resetn),
        .Start(Start),
        .DropTick(DropTick),
        .SoftDrop(SoftDrop),
        .Pause(Pause),
        .canMove(canMove),
        .checkEnable(checkEnable),
        .YPOS(YPOS),
        .lockPiece(lockPiece),
        .pieceActive(pieceActive),
        .gameOver(gameOver)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Checker model: canMove is the registered answer to checkEnable.
    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) canMove <= 1'b0;
        else         canMove <= checkEnable & resp;
    end

    // Pulse counters sampled away from the active edge.
    initial begin
        ce_n = 0;
        lk_n = 0;
        lk_y = 5'd0;
    end
    always @(negedge Clock) begin
        if (checkEnable) ce_n = ce_n + 1;
        if (lockPiece) begin
            lk_n = lk_n + 1;
            lk_y = YPOS;
        end
    end

    typedef struct {
        logic       st;
        logic       tk;
        logic       ps;
        logic       rs;
        logic       ce;
        logic [4:0] y;
        logic       lk;
        logic       act;
        logic       go;
    } vec_t;

    vec_t vt[13];

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic tick_wait(input int n);
        DropTick = 1'b1;
        cyc();
        DropTick = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic check(input string name, input int got, input int exp);
        total = total + 1;
        if (got != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_ce"}, int'(checkEnable), 0);
        check({name, "_y"}, int'(YPOS), 0);
        check({name, "_lk"}, int'(lockPiece), 0);
        check({name, "_act"}, int'(pieceActive), 0);
        check({name, "_go"}, int'(gameOver), 0);
    endtask

    initial begin
        int b_ce;
        int b_lk;
        int got;
        int exp;

        total    = 0;
        bad      = 0;
        Resetn   = 1'b0;
        Start    = 1'b0;
        DropTick = 1'b0;
        SoftDrop = 1'b0;
        Pause    = 1'b0;
        resp     = 1'b0;

        //          st  tk  ps  rs  ce  y   lk  act go
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};

        repeat (2) cyc();
        check_reset("reset");
        Resetn = 1'b1;
        cyc();

        // Cycle-accurate table: latency, ignored extra tick, pause, lock.
        for (int i = 0; i < 13; i++) begin
            Start    = vt[i].st;
            DropTick = vt[i].tk;
            Pause    = vt[i].ps;
            resp     = vt[i].rs;
            cyc();
            got = int'({checkEnable, YPOS, lockPiece, pieceActive, gameOver});
            exp = int'({vt[i].ce, vt[i].y, vt[i].lk, vt[i].act, vt[i].go});
            if (got != exp) begin
                $display("FAIL vec%0d: got ce=%0b y=%0d lk=%0b act=%0b go=%0b expected ce=%0b y=%0d lk=%0b act=%0b go=%0b",
                         i, checkEnable, YPOS, lockPiece, pieceActive, gameOver,
                         vt[i].ce, vt[i].y, vt[i].lk, vt[i].act, vt[i].go);
                bad = bad + 1;
            end
            total = total + 1;
        end
        Start = 1'b0;
        DropTick = 1'b0;
        Pause = 1'b0;

        // Full fall to the floor, then lock at the floor.
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        resp = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            b_ce = ce_n;
            tick_wait(9);
            check($sformatf("fall_y%0d", k), int'(YPOS), k);
            check($sformatf("fall_ce%0d", k), ce_n - b_ce, 1);
        end
        b_ce = ce_n;
        b_lk = lk_n;
        tick_wait(9);
        check("floor_no_ce", ce_n - b_ce, 0);
        check("floor_no_lock", lk_n - b_lk, 0);
        check("floor_y", int'(YPOS), 16);
        tick_wait(9);
        check("floor_lock", lk_n - b_lk, 1);
        check("floor_lock_y", int'(lk_y), 16);
        check("floor_act", int'(pieceActive), 0);
        check("floor_go", int'(gameOver), 0);

        // Lock at spawn row: game over, later Start ignored.
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        resp = 1'b0;
        b_lk = lk_n;
        tick_wait(9);
        tick_wait(9);
        check("spawn_lock", lk_n - b_lk, 1);
        check("spawn_lock_y", int'(lk_y), 0);
        check("spawn_go", int'(gameOver), 1);
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        repeat (3) cyc();
        check("go_start_ignored", int'(pieceActive), 0);

        // Reset clears sticky game over.
        Resetn = 1'b0;
        cyc();
        check_reset("reset2");
        Resetn = 1'b1;
        cyc();

        // Soft drop: checks every 4 cycles of FALL residence.
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        SoftDrop = 1'b1;
        resp = 1'b1;
        b_ce = ce_n;
        repeat (20) cyc();
        check("soft_ce", ce_n - b_ce, 3);
        check("soft_y", int'(YPOS), 3);
        SoftDrop = 1'b0;
        cyc();
        b_ce = ce_n;
        repeat (20) cyc();
        check("soft_off_ce", ce_n - b_ce, 0);
        check("soft_off_y", int'(YPOS), 3);

        // Lock counter clears on a successful move.
        tick_wait(9);
        tick_wait(9);
        check("lc_y5", int'(YPOS), 5);
        b_lk = lk_n;
        resp = 1'b0;
        tick_wait(9);
        resp = 1'b1;
        tick_wait(9);
        check("lc_y6", int'(YPOS), 6);
        resp = 1'b0;
        tick_wait(9);
        check("lc_no_lock", lk_n - b_lk, 0);
        tick_wait(9);
        check("lc_lock", lk_n - b_lk, 1);
        check("lc_lock_y", int'(lk_y), 6);

        // Reset during EVAL abandons the evaluation.
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        resp = 1'b0;
        tick_wait(1);
        b_lk = lk_n;
        Resetn = 1'b0;
        #1;
        check_reset("rst_eval");
        repeat (2) cyc();
        Resetn = 1'b1;
        repeat (5) cyc();
        check("rst_eval_no_lock", lk_n - b_lk, 0);
        check("rst_eval_act", int'(pieceActive), 0);

        // Pause freezes evaluation.
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        Pause = 1'b1;
        resp = 1'b1;
        b_ce = ce_n;
        for (int i = 0; i < 3; i++) tick_wait(5);
        check("pause_ce", ce_n - b_ce, 0);
        check("pause_y", int'(YPOS), 0);
        check("pause_act", int'(pieceActive), 1);
        Pause = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
